// File: rtl/debug_mem_bridge_pkg.sv
// Shared register map, status/control bit positions and bus FSM encoding
// for the JTAG debug memory bridge.
package debug_mem_bridge_pkg;

    localparam logic [2:0] REG_ID      = 3'd0;
    localparam logic [2:0] REG_ADDR    = 3'd1;
    localparam logic [2:0] REG_DATA    = 3'd2;
    localparam logic [2:0] REG_CTRL    = 3'd3;
    localparam logic [2:0] REG_STATUS  = 3'd4;
    localparam logic [2:0] REG_SCRATCH = 3'd5;

    localparam int CTRL_GO      = 0;
    localparam int CTRL_AUTOINC = 1;

    localparam int STAT_BUSY = 0;
    localparam int STAT_ERR  = 1;
    localparam int STAT_DONE = 2;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_BUS_WR = 2'd1,
        ST_BUS_RD = 2'd2
    } bus_state_t;

endpackage

// File: rtl/debug_mem_bridge_timeout_ctr.sv
// Bus watchdog: counts cycles while enabled and flags the cycle in which
// the count would reach TIMEOUT.
module bus_timeout_ctr #(
    parameter int TIMEOUT = 255
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    input  logic en,
    output logic expire
);
    localparam int W = $clog2(TIMEOUT + 1);
    localparam logic [W-1:0] TERM = W'(TIMEOUT);
    localparam logic [W-1:0] LAST = W'(TIMEOUT - 1);

    logic [W-1:0] cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (en && (cnt != TERM)) begin
            cnt <= cnt + 1'b1;
        end
    end

    // Flagging one count early makes the request last exactly TIMEOUT cycles.
    assign expire = en && (cnt == LAST);

endmodule

// File: rtl/debug_mem_bridge.sv
// Debug-port register file that turns DATA/CTRL accesses into single-word
// req/ack bus transactions with auto-increment, status and timeout.
//
// state     | meaning
// ST_IDLE   | no transaction, bus request low
// ST_BUS_WR | write in flight, waiting for ack or timeout
// ST_BUS_RD | read in flight, waiting for ack or timeout
module debug_mem_bridge #(
    parameter logic [31:0] ID_VALUE = 32'h44425031,
    parameter int          TIMEOUT  = 255,
    parameter int          ADDR_INC = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        i_rd,
    input  logic        i_wr,
    input  logic [2:0]  i_addr,
    input  logic [31:0] i_wdata,
    output logic [31:0] o_rdata,
    output logic        o_bus_req,
    output logic        o_bus_we,
    output logic [31:0] o_bus_addr,
    output logic [31:0] o_bus_wdata,
    input  logic        i_bus_ack,
    input  logic [31:0] i_bus_rdata
);
    import debug_mem_bridge_pkg::*;

    bus_state_t state, state_nxt;

    logic [31:0] addr_q;
    logic [31:0] rdata_q;
    logic [31:0] scratch_q;
    logic        autoinc_q;
    logic        err_q;
    logic        done_q;

    logic        busy;
    logic        expire;
    logic        wr_addr, wr_data, wr_ctrl, wr_status, wr_scratch;
    logic        launch_wr, launch_rd;
    logic        busy_drop;
    logic        ack_hit;
    logic        timeout_hit;
    logic [31:0] rd_mux;

    assign busy       = (state != ST_IDLE);
    assign wr_addr    = i_wr && (i_addr == REG_ADDR);
    assign wr_data    = i_wr && (i_addr == REG_DATA);
    assign wr_ctrl    = i_wr && (i_addr == REG_CTRL);
    assign wr_status  = i_wr && (i_addr == REG_STATUS);
    assign wr_scratch = i_wr && (i_addr == REG_SCRATCH);

    assign launch_wr   = wr_data && !busy;
    assign launch_rd   = wr_ctrl && i_wdata[CTRL_GO] && !busy;
    assign busy_drop   = busy && (wr_addr || wr_data || wr_ctrl);
    assign ack_hit     = busy && i_bus_ack;
    // An ack in the expiry cycle still completes the transaction cleanly.
    assign timeout_hit = expire && !i_bus_ack;

    assign o_bus_req = busy;

    bus_timeout_ctr #(
        .TIMEOUT (TIMEOUT)
    ) u_timeout (
        .clk    (clk),
        .rst_n  (rst_n),
        .clr    (!busy),
        .en     (busy),
        .expire (expire)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            ST_IDLE: begin
                if (launch_wr) begin
                    state_nxt = ST_BUS_WR;
                end else if (launch_rd) begin
                    state_nxt = ST_BUS_RD;
                end
            end
            ST_BUS_WR, ST_BUS_RD: begin
                if (i_bus_ack || expire) begin
                    state_nxt = ST_IDLE;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        rd_mux = '0;
        unique case (i_addr)
            REG_ID:      rd_mux = ID_VALUE;
            REG_ADDR:    rd_mux = addr_q;
            REG_DATA:    rd_mux = rdata_q;
            REG_CTRL:    rd_mux = {30'b0, autoinc_q, 1'b0};
            REG_STATUS:  rd_mux = {29'b0, done_q, err_q, busy};
            REG_SCRATCH: rd_mux = scratch_q;
            default:     rd_mux = '0;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            o_bus_we    <= 1'b0;
            o_bus_addr  <= '0;
            o_bus_wdata <= '0;
        end else if (launch_wr) begin
            o_bus_we    <= 1'b1;
            o_bus_addr  <= addr_q;
            o_bus_wdata <= i_wdata;
        end else if (launch_rd) begin
            o_bus_we    <= 1'b0;
            o_bus_addr  <= addr_q;
            o_bus_wdata <= '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            addr_q    <= '0;
            rdata_q   <= '0;
            scratch_q <= '0;
            autoinc_q <= 1'b0;
            err_q     <= 1'b0;
            done_q    <= 1'b0;
            o_rdata   <= '0;
        end else begin
            if (i_rd) begin
                o_rdata <= rd_mux;
            end

            if (wr_addr && !busy) begin
                addr_q <= i_wdata;
            end else if (ack_hit && autoinc_q) begin
                addr_q <= addr_q + 32'(ADDR_INC);
            end

            if (ack_hit && (state == ST_BUS_RD)) begin
                rdata_q <= i_bus_rdata;
            end

            if (wr_ctrl && !busy) begin
                autoinc_q <= i_wdata[CTRL_AUTOINC];
            end

            if (wr_scratch) begin
                scratch_q <= i_wdata;
            end

            // Setting events take priority over a same-cycle software clear.
            if (timeout_hit || busy_drop) begin
                err_q <= 1'b1;
            end else if (wr_status && i_wdata[STAT_ERR]) begin
                err_q <= 1'b0;
            end

            if (ack_hit) begin
                done_q <= 1'b1;
            end else if (wr_status && i_wdata[STAT_DONE]) begin
                done_q <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_debug_mem_bridge.sv
// Scoreboard bench for debug_mem_bridge: expected read data and bus requests
// are queued by the stimulus and checked by independent monitors.
module tb_debug_mem_bridge;

    typedef struct {
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        bit          chk_wd;
    } bus_exp_t;

    logic        clk;
    logic        rst_n;
    logic        i_rd;
    logic        i_wr;
    logic [2:0]  i_addr;
    logic [31:0] i_wdata;
    logic [31:0] o_rdata;
    logic        o_bus_req;
    logic        o_bus_we;
    logic [31:0] o_bus_addr;
    logic [31:0] o_bus_wdata;
    logic        i_bus_ack;
    logic [31:0] i_bus_rdata;

    int          n_tests = 0;
    int          n_fail  = 0;
    logic [31:0] rd_q[$];
    bus_exp_t    bus_q[$];
    bus_exp_t    cur_exp;
    logic        rd_d = 1'b0;
    logic        req_prev = 1'b0;
    int          ack_delay = 0;
    int          req_cyc = 0;
    logic [31:0] slave_rdata = '0;

    debug_mem_bridge #(
        .ID_VALUE (32'h44425031),
        .TIMEOUT  (8),
        .ADDR_INC (4)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .i_rd        (i_rd),
        .i_wr        (i_wr),
        .i_addr      (i_addr),
        .i_wdata     (i_wdata),
        .o_rdata     (o_rdata),
        .o_bus_req   (o_bus_req),
        .o_bus_we    (o_bus_we),
        .o_bus_addr  (o_bus_addr),
        .o_bus_wdata (o_bus_wdata),
        .i_bus_ack   (i_bus_ack),
        .i_bus_rdata (i_bus_rdata)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic reg_rd(input logic [2:0] a, input logic [31:0] exp);
        rd_q.push_back(exp);
        i_rd = 1'b1;
        i_addr = a;
        @(posedge clk); #1;
        i_rd = 1'b0;
    endtask

    task automatic reg_wr(input logic [2:0] a, input logic [31:0] d);
        i_wr = 1'b1;
        i_addr = a;
        i_wdata = d;
        @(posedge clk); #1;
        i_wr = 1'b0;
    endtask

    task automatic expect_bus(input logic we, input logic [31:0] a, input logic [31:0] d, input bit cw);
        bus_exp_t e;
        e.we = we;
        e.addr = a;
        e.wdata = d;
        e.chk_wd = cw;
        bus_q.push_back(e);
    endtask

    task automatic wait_idle();
        for (int i = 0; i < 40; i++) begin
            if (!o_bus_req) break;
            @(posedge clk); #1;
        end
        chk("bus_idle_timeout", {31'b0, o_bus_req}, 32'h0);
    endtask

    // Bus slave: acks on the ack_delay-th cycle of a request (0 = never).
    initial begin
        i_bus_ack = 1'b0;
        i_bus_rdata = '0;
        forever begin
            @(posedge clk); #1;
            i_bus_ack = 1'b0;
            if (o_bus_req) req_cyc++;
            else req_cyc = 0;
            if (o_bus_req && ack_delay > 0 && req_cyc == ack_delay) begin
                i_bus_ack = 1'b1;
                i_bus_rdata = slave_rdata;
            end
        end
    end

    always @(posedge clk) rd_d = i_rd;

    always @(negedge clk) begin
        if (rd_d) begin
            if (rd_q.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL rdata_unexpected: got %h expected no read", o_rdata);
            end else begin
                chk("rdata", o_rdata, rd_q.pop_front());
            end
        end
        if (o_bus_req && !req_prev) begin
            if (bus_q.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL bus_unexpected: got req addr %h expected no request", o_bus_addr);
            end else begin
                cur_exp = bus_q.pop_front();
                chk("bus_we", {31'b0, o_bus_we}, {31'b0, cur_exp.we});
                chk("bus_addr", o_bus_addr, cur_exp.addr);
                if (cur_exp.chk_wd) chk("bus_wdata", o_bus_wdata, cur_exp.wdata);
            end
        end else if (o_bus_req && req_prev) begin
            chk("bus_addr_stable", o_bus_addr, cur_exp.addr);
        end
        req_prev = o_bus_req;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int req_cnt;
        rst_n = 1'b0;
        i_rd = 1'b0;
        i_wr = 1'b0;
        i_addr = '0;
        i_wdata = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_rdata", o_rdata, 32'h0);
        chk("reset_req", {31'b0, o_bus_req}, 32'h0);
        chk("reset_bus_addr", o_bus_addr, 32'h0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        reg_rd(3'd0, 32'h44425031);
        reg_rd(3'd4, 32'h0);
        reg_rd(3'd6, 32'h0);

        // Bus write with ack after 3 cycles
        reg_wr(3'd1, 32'h0000_1000);
        ack_delay = 3;
        expect_bus(1'b1, 32'h0000_1000, 32'hCAFE_F00D, 1'b1);
        reg_wr(3'd2, 32'hCAFE_F00D);
        wait_idle();
        reg_rd(3'd4, 32'h4);
        reg_rd(3'd1, 32'h0000_1000);
        reg_wr(3'd4, 32'h4);

        // Reads with auto-increment
        slave_rdata = 32'h1234_5678;
        expect_bus(1'b0, 32'h0000_1000, 32'h0, 1'b0);
        reg_wr(3'd3, 32'h3);
        wait_idle();
        reg_rd(3'd2, 32'h1234_5678);
        reg_rd(3'd1, 32'h0000_1004);
        reg_rd(3'd3, 32'h2);
        slave_rdata = 32'hDEAD_BEEF;
        expect_bus(1'b0, 32'h0000_1004, 32'h0, 1'b0);
        reg_wr(3'd3, 32'h3);
        wait_idle();
        reg_rd(3'd2, 32'hDEAD_BEEF);
        reg_rd(3'd1, 32'h0000_1008);
        reg_wr(3'd3, 32'h0);
        reg_rd(3'd3, 32'h0);
        reg_wr(3'd4, 32'h4);
        reg_rd(3'd4, 32'h0);

        // Ack coinciding with the timeout cycle: ack wins
        ack_delay = 8;
        slave_rdata = 32'h0BAD_CAFE;
        expect_bus(1'b0, 32'h0000_1008, 32'h0, 1'b0);
        reg_wr(3'd3, 32'h1);
        wait_idle();
        reg_rd(3'd4, 32'h4);
        reg_rd(3'd2, 32'h0BAD_CAFE);
        reg_rd(3'd1, 32'h0000_1008);
        reg_wr(3'd4, 32'h4);

        // Timeout: request high for exactly 8 cycles
        ack_delay = 0;
        expect_bus(1'b0, 32'h0000_1008, 32'h0, 1'b0);
        reg_wr(3'd3, 32'h1);
        req_cnt = 0;
        while (o_bus_req && req_cnt < 100) begin
            req_cnt++;
            @(posedge clk); #1;
        end
        chk("timeout_req_cycles", 32'(req_cnt), 32'd8);
        reg_rd(3'd4, 32'h2);
        reg_rd(3'd1, 32'h0000_1008);
        reg_wr(3'd4, 32'h2);
        reg_rd(3'd4, 32'h0);

        // Writes while busy
        expect_bus(1'b1, 32'h0000_1008, 32'h1111_1111, 1'b1);
        reg_wr(3'd2, 32'h1111_1111);
        reg_wr(3'd1, 32'h0000_2000);
        reg_wr(3'd5, 32'hA5A5_A5A5);
        reg_rd(3'd5, 32'hA5A5_A5A5);
        reg_rd(3'd4, 32'h3);
        reg_rd(3'd1, 32'h0000_1008);
        reg_rd(3'd2, 32'h0BAD_CAFE);
        wait_idle();
        reg_rd(3'd4, 32'h2);
        reg_wr(3'd4, 32'h6);
        reg_rd(3'd4, 32'h0);

        // Asynchronous reset mid-transaction
        expect_bus(1'b0, 32'h0000_1008, 32'h0, 1'b0);
        reg_wr(3'd3, 32'h3);
        @(posedge clk); #3;
        chk("req_before_reset", {31'b0, o_bus_req}, 32'h1);
        rst_n = 1'b0;
        #1;
        chk("req_async_drop", {31'b0, o_bus_req}, 32'h0);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        reg_rd(3'd1, 32'h0);
        reg_rd(3'd4, 32'h0);
        reg_rd(3'd5, 32'h0);
        reg_rd(3'd3, 32'h0);

        repeat (3) @(posedge clk);
        #1;
        chk("rd_queue_drained", 32'(rd_q.size()), 32'd0);
        chk("bus_queue_drained", 32'(bus_q.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
